// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC, req/ack instruction-memory reads and the IF/ID register, 1-cycle ack-to-IF/ID latency.
// A stall parks one returned instruction in a hold buffer; a redirect flushes IF/ID and drops any in-flight read.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [5:0]  ifid_opcode,
  output logic [31:0] ifid_pc_plus4
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] drop_addr, drop_addr_next;
  logic [31:0] hold_instr, hold_instr_next;
  logic [31:0] hold_pc_plus4, hold_pc_plus4_next;
  logic        valid_next;
  logic [31:0] instr_next, pc_plus4_next;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_inc;

  assign redirect = branch_taken | jump;
  // Branch wins over jump: it belongs to the older instruction.
  assign target   = branch_taken ? (branch_target & 32'hFFFF_FFFC)
                                 : {ifid_pc_plus4[31:28], jump_index, 2'b00};
  assign pc_inc   = pc + 32'd4;

  assign imem_req    = (state == FETCH) || (state == DROP);
  assign imem_addr   = (state == DROP) ? drop_addr : pc;
  assign ifid_opcode = ifid_instr[31:26];

  always_comb begin
    state_next         = state;
    pc_next            = pc;
    drop_addr_next     = drop_addr;
    hold_instr_next    = hold_instr;
    hold_pc_plus4_next = hold_pc_plus4;
    valid_next         = ifid_valid;
    instr_next         = ifid_instr;
    pc_plus4_next      = ifid_pc_plus4;

    if (redirect) begin
      valid_next = 1'b0;
      instr_next = 32'h0;
      pc_next    = target;
    end

    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (redirect) begin
          if (!imem_ack) begin
            drop_addr_next = pc;
            state_next     = DROP;
          end
        end else if (imem_ack) begin
          pc_next = pc_inc;
          if (stall) begin
            hold_instr_next    = imem_rdata;
            hold_pc_plus4_next = pc_inc;
            state_next         = HOLD;
          end else begin
            valid_next    = 1'b1;
            instr_next    = imem_rdata;
            pc_plus4_next = pc_inc;
          end
        end else if (!stall) begin
          valid_next = 1'b0;
          instr_next = 32'h0;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_next = FETCH;
        end else if (!stall) begin
          valid_next    = 1'b1;
          instr_next    = hold_instr;
          pc_plus4_next = hold_pc_plus4;
          state_next    = FETCH;
        end
      end
      DROP: begin
        // The outstanding read must complete before the target is requested.
        if (imem_ack) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      drop_addr     <= RESET_PC;
      hold_instr    <= 32'h0;
      hold_pc_plus4 <= 32'h0;
      ifid_valid    <= 1'b0;
      ifid_instr    <= 32'h0;
      ifid_pc_plus4 <= 32'h0;
    end else begin
      state         <= state_next;
      pc            <= pc_next;
      drop_addr     <= drop_addr_next;
      hold_instr    <= hold_instr_next;
      hold_pc_plus4 <= hold_pc_plus4_next;
      ifid_valid    <= valid_next;
      ifid_instr    <= instr_next;
      ifid_pc_plus4 <= pc_plus4_next;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: streaming, stall/hold, branch/jump redirects, PC wrap and async reset.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic        use_fixed;
  logic [31:0] fixed_data;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [5:0]  ifid_opcode;
  logic [31:0] ifid_pc_plus4;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [5:0]  w_opcode;
  logic [31:0] w_pc_plus4;

  int checks = 0;
  int errors = 0;

  // Memory contents are a fixed scramble of the address unless overridden.
  assign imem_rdata = use_fixed ? fixed_data : (imem_addr ^ 32'h5A5A_0000);

  instruction_fetch #(.RESET_PC(32'h0040_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_opcode(ifid_opcode), .ifid_pc_plus4(ifid_pc_plus4)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index),
    .ifid_valid(w_valid), .ifid_instr(w_instr),
    .ifid_opcode(w_opcode), .ifid_pc_plus4(w_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req"},   {31'h0, imem_req},   32'h0);
    check({tag, " addr"},  imem_addr,           32'h0040_0000);
    check({tag, " valid"}, {31'h0, ifid_valid}, 32'h0);
    check({tag, " instr"}, ifid_instr,          32'h0);
    check({tag, " op"},    {26'h0, ifid_opcode}, 32'h0);
    check({tag, " pc4"},   ifid_pc_plus4,       32'h0);
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b1; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_index = 26'h0;
    use_fixed = 1'b0; fixed_data = 32'h0;

    tick(); tick();
    check_reset_outputs("rst");
    check("rst wrap addr", w_addr, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    // Streaming with always-ack memory
    tick();
    check("p1 req",   {31'h0, imem_req},   32'h1);
    check("p1 addr",  imem_addr,           32'h0040_0000);
    check("p1 valid", {31'h0, ifid_valid}, 32'h0);
    tick();
    check("p2 addr",  imem_addr,           32'h0040_0004);
    check("p2 valid", {31'h0, ifid_valid}, 32'h1);
    check("p2 instr", ifid_instr,          32'h5A1A_0000);
    check("p2 pc4",   ifid_pc_plus4,       32'h0040_0004);
    check("wrap addr", w_addr,             32'h0000_0000);
    check("wrap pc4",  w_pc_plus4,         32'h0000_0000);
    check("wrap valid", {31'h0, w_valid},  32'h1);
    tick();
    check("p3 addr",  imem_addr,           32'h0040_0008);
    check("p3 pc4",   ifid_pc_plus4,       32'h0040_0008);

    // Stall while 0x8C080000 is returned
    stall = 1'b1; use_fixed = 1'b1; fixed_data = 32'h8C08_0000;
    tick();
    use_fixed = 1'b0;
    check("hold req",   {31'h0, imem_req},   32'h0);
    check("hold instr", ifid_instr,          32'h5A1A_0004);
    check("hold pc4",   ifid_pc_plus4,       32'h0040_0008);
    check("hold valid", {31'h0, ifid_valid}, 32'h1);
    tick();
    check("hold2 req",   {31'h0, imem_req}, 32'h0);
    check("hold2 instr", ifid_instr,        32'h5A1A_0004);
    tick();
    stall = 1'b0;
    tick();
    check("unhold instr", ifid_instr,          32'h8C08_0000);
    check("unhold op",    {26'h0, ifid_opcode}, 32'h23);
    check("unhold pc4",   ifid_pc_plus4,       32'h0040_000C);
    check("unhold addr",  imem_addr,           32'h0040_000C);
    tick();
    check("after hold instr", ifid_instr,    32'h5A1A_000C);
    check("after hold pc4",   ifid_pc_plus4, 32'h0040_0010);

    // Taken branch with ack: flush and retarget, low bits ignored
    branch_taken = 1'b1; branch_target = 32'h0040_0103;
    tick();
    branch_taken = 1'b0;
    check("br valid", {31'h0, ifid_valid}, 32'h0);
    check("br instr", ifid_instr,          32'h0);
    check("br addr",  imem_addr,           32'h0040_0100);
    tick();
    check("br pc4",   ifid_pc_plus4,       32'h0040_0104);

    // Move to 0x10000004 so IF/ID pc_plus4 becomes 0x10000008
    branch_taken = 1'b1; branch_target = 32'h1000_0004;
    tick();
    branch_taken = 1'b0;
    tick();
    check("setup pc4", ifid_pc_plus4, 32'h1000_0008);

    // Jump during a delayed ack: old read must finish and be discarded
    imem_ack = 1'b0; jump = 1'b1; jump_index = 26'h40;
    tick();
    jump = 1'b0;
    check("drop addr",  imem_addr,           32'h1000_0008);
    check("drop req",   {31'h0, imem_req},   32'h1);
    check("drop valid", {31'h0, ifid_valid}, 32'h0);
    tick();
    check("drop addr2", imem_addr,           32'h1000_0008);
    imem_ack = 1'b1;
    tick();
    check("jmp addr",   imem_addr,           32'h1000_0100);
    check("jmp valid0", {31'h0, ifid_valid}, 32'h0);
    tick();
    check("jmp instr",  ifid_instr,          32'h4A5A_0100);
    check("jmp pc4",    ifid_pc_plus4,       32'h1000_0104);

    // Branch and jump together during a wait: branch wins
    imem_ack = 1'b0; jump = 1'b1; jump_index = 26'h40;
    branch_taken = 1'b1; branch_target = 32'h0000_0200;
    tick();
    jump = 1'b0; branch_taken = 1'b0;
    check("pri drop addr", imem_addr, 32'h1000_0104);
    tick();
    imem_ack = 1'b1;
    tick();
    check("pri addr", imem_addr, 32'h0000_0200);

    // Asynchronous reset in the middle of a HOLD
    stall = 1'b1;
    tick();
    check("pre-rst hold req", {31'h0, imem_req}, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    stall = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("restart req",  {31'h0, imem_req}, 32'h1);
    check("restart addr", imem_addr,         32'h0040_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the MIPS pipeline: owns the program counter, issues word reads to instruction memory over a req/ack handshake, and holds the IF/ID pipeline register whose opcode field drives the control unit. Supports hazard stalls, a one-entry hold buffer for instructions returned during a stall, and redirection by taken branches and jumps with flush. Sits between instruction memory and the decode/control stage.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset; low 2 bits must be 0.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request; held high until imem_ack.
- imem_addr  out  32  word address of the request; stable while imem_req high and no ack.
- imem_ack  in  1  imem_rdata valid this cycle; completes the request.
- imem_rdata  in  32  fetched instruction.
- stall  in  1  hazard stall from decode; IF/ID must hold.
- branch_taken  in  1  branch resolved taken; redirect to branch_target.
- branch_target  in  32  branch destination; bits [1:0] ignored (treated as 0).
- jump  in  1  jump decoded for the instruction in IF/ID.
- jump_index  in  26  instr_index field of that jump.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  32  IF/ID instruction; 32'h0 (nop) when not valid.
- ifid_opcode  out  6  ifid_instr[31:26]; feeds the control unit.
- ifid_pc_plus4  out  32  address of ifid_instr plus 4.

## Operation
- States: IDLE, FETCH, HOLD, DROP. imem_req = 1 in FETCH and DROP only; imem_addr = pc in FETCH, drop_addr in DROP.
- IDLE: entered on reset; goes to FETCH next cycle.
- FETCH, no redirect: on ack and !stall, load IF/ID with rdata, valid=1, pc_plus4=pc+4; pc<=pc+4; stay. On ack and stall: capture rdata/pc+4 into hold buffer, pc<=pc+4, go HOLD. No ack and !stall: ifid_valid<=0, ifid_instr<=0 (bubble). No ack and stall: IF/ID holds.
- HOLD: imem_req=0; IF/ID holds while stall; when stall drops, move buffer into IF/ID (valid=1), go FETCH.
- Redirect = branch_taken | jump. Target: branch_taken ? {branch_target[31:2],2'b00} : {ifid_pc_plus4[31:28], jump_index, 2'b00}. branch_taken has priority (older instruction).
- Redirect overrides stall: IF/ID flushed (valid=0, instr=0), hold buffer discarded, pc<=target.
- Redirect in FETCH with ack, or in HOLD/IDLE: next state FETCH at target. Redirect in FETCH without ack: drop_addr<=current pc, go DROP; keep request stable; on ack discard data, go FETCH. A further redirect in DROP overwrites pc (latest wins).
- PC arithmetic modulo 2^32: pc+4 from 32'hFFFF_FFFC yields 32'h0000_0000.

## Timing
- Reset (asynchronous assert, any state): pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, ifid_valid=0, ifid_instr=0, ifid_opcode=0, ifid_pc_plus4=0, hold buffer empty.
- First request in the 2nd cycle after rst_n rises (cycle after IDLE).
- Latency: instruction visible on IF/ID one cycle after its ack edge; zero-wait memory sustains one instruction per cycle.
- Redirect: first request at the target issued the cycle after the redirect (FETCH/HOLD), or the cycle after the pending ack (DROP).
- No instruction lost or duplicated across any stall/ack/redirect combination; at most one buffered instruction.

## Test plan
- RESET_PC=0x0040_0000, always-ack memory -> imem_addr 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; ifid_pc_plus4 0x00400004, ...; ifid_valid from 3rd cycle after reset release.
- stall high 3 cycles while ack returns 0x8C080000 -> HOLD, imem_req=0, IF/ID unchanged; 1 cycle after stall drops IF/ID=0x8C080000, ifid_opcode=6'b100011; next fetch at following address, no duplicate.
- branch_taken with branch_target 0x0040_0103 during FETCH+ack -> IF/ID flushed (valid 0, instr 0), next imem_addr 0x0040_0100.
- Memory ack delayed 2 cycles, jump asserted in 1st wait cycle with ifid_pc_plus4=0x1000_0008, jump_index=26'h40 -> addr held until ack, data discarded, then imem_addr 0x1000_0100; same cycle branch_taken to 0x200 instead -> 0x0000_0200 wins.
- RESET_PC=0xFFFF_FFFC, always-ack -> second address 0x0000_0000, ifid_pc_plus4 0x0000_0000.
- rst_n dropped mid-HOLD with stall high -> all outputs at reset values immediately, without a clock edge; restart fetches RESET_PC.
